// File: rtl/bcrypt_wr_addr_seq.sv
// Write-address sequencer for bcrypt key expansion.
// Walks the P-array pairs, then S-box 0..3 pairs, one pair per en step,
// and drives the pair address plus one-hot chip selects.
module bcrypt_wr_addr_seq #(
   parameter int P_PAIRS = 9,
   parameter int S_PAIRS = 128,
   parameter int N_SBOX  = 4
) (
   input  logic       clk_2,
   input  logic       int_rst_l,
   input  logic       start,
   input  logic       en,
   output logic [6:0] wr_addr,
   output logic       csp,
   output logic       cs0,
   output logic       cs1,
   output logic       cs2,
   output logic       cs3,
   output logic       last,
   output logic       busy,
   output logic       done
);

   localparam int AW = $clog2(S_PAIRS);

   // One-hot state: each bit is a chip select, so the selects come
   // straight off flops. IDLE is all-zero.
   localparam logic [4:0] IDLE   = 5'b00000;
   localparam logic [4:0] SEG_P  = 5'b00001;
   localparam logic [4:0] SEG_S0 = 5'b00010;
   localparam logic [4:0] SEG_S1 = 5'b00100;
   localparam logic [4:0] SEG_S2 = 5'b01000;
   localparam logic [4:0] SEG_S3 = 5'b10000;

   logic [4:0]    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          done_q, done_d;
   logic          seg_end;

   // Final pair of the current segment (P array is shorter than an S-box)
   assign seg_end = (state_q == SEG_P) ? (addr_q == AW'(P_PAIRS - 1))
                                       : (addr_q == AW'(S_PAIRS - 1));

   // State, address and done registers
   always_ff @(posedge clk_2 or negedge int_rst_l) begin
      if (!int_rst_l) begin
         state_q <= IDLE;
         addr_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
      end
   end

   // Next state: start beats en; en steps the address or crosses a segment
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      done_d  = 1'b0;
      if (start) begin
         state_d = SEG_P;
         addr_d  = '0;
      end else if (en) begin
         if (!seg_end) begin
            addr_d = addr_q + AW'(1);
         end else begin
            addr_d = '0;
            case (state_q)
               SEG_P:   state_d = SEG_S0;
               SEG_S0:  state_d = SEG_S1;
               SEG_S1:  state_d = SEG_S2;
               SEG_S2:  state_d = SEG_S3;
               SEG_S3: begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
               default: state_d = IDLE;
            endcase
         end
         // en is meaningless while idle: keep the address parked at 0
         if (state_q == IDLE) begin
            state_d = IDLE;
            addr_d  = '0;
            done_d  = 1'b0;
         end
      end
   end

   // Outputs decoded from the registered state
   always_comb begin
      wr_addr = 7'(addr_q);
      csp     = state_q[0];
      cs0     = state_q[1];
      cs1     = state_q[2];
      cs2     = state_q[3];
      cs3     = state_q[N_SBOX];
      busy    = |state_q;
      last    = (state_q == SEG_S3) && (addr_q == AW'(S_PAIRS - 1));
      done    = done_q;
   end

endmodule

// File: tb/tb_bcrypt_wr_addr_seq.sv
// Bench for bcrypt_wr_addr_seq: directed table, hand-written corner
// sequences and random stimulus, all checked against a step-index model.
module tb_bcrypt_wr_addr_seq;

   logic       clk_2 = 1'b0;
   logic       int_rst_l = 1'b0;
   logic       start = 1'b0;
   logic       en = 1'b0;
   logic [6:0] wr_addr;
   logic       csp, cs0, cs1, cs2, cs3, last, busy, done;

   int n_chk = 0;
   int n_pass = 0;

   bcrypt_wr_addr_seq dut (
      .clk_2(clk_2), .int_rst_l(int_rst_l), .start(start), .en(en),
      .wr_addr(wr_addr), .csp(csp), .cs0(cs0), .cs1(cs1), .cs2(cs2),
      .cs3(cs3), .last(last), .busy(busy), .done(done)
   );

   always #5 clk_2 = ~clk_2;

   // Model: a sequence is just a step index 0..520 over 9 + 4*128 pairs
   localparam int TOTAL = 9 + 4 * 128;
   bit m_act = 0;
   int m_idx = 0;
   bit m_done = 0;

   function automatic logic [14:0] outs();
      return {wr_addr, csp, cs0, cs1, cs2, cs3, last, busy, done};
   endfunction

   function automatic logic [14:0] mdl_out();
      int seg, addr;
      logic [4:0] cs;
      if (!m_act) return {12'd0, 1'b0, 1'b0, m_done};
      if (m_idx < 9) begin
         seg = 0; addr = m_idx;
      end else begin
         seg = 1 + (m_idx - 9) / 128; addr = (m_idx - 9) % 128;
      end
      cs = 5'b10000 >> seg;
      return {7'(addr), cs, (m_idx == TOTAL - 1), 1'b1, 1'b0};
   endfunction

   function automatic void mdl_step(input bit s, input bit e);
      m_done = 0;
      if (s) begin
         m_act = 1; m_idx = 0;
      end else if (m_act && e) begin
         if (m_idx == TOTAL - 1) begin
            m_act = 0; m_idx = 0; m_done = 1;
         end else m_idx++;
      end
   endfunction

   task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
   endtask

   // One clock: drive, clock, advance model, compare #1 after the edge
   task automatic cycle(input bit s, input bit e, input string name);
      start = s; en = e;
      @(posedge clk_2);
      mdl_step(s, e);
      #1;
      chk(name, outs(), mdl_out());
      start = 0; en = 0;
   endtask

   task automatic do_reset();
      int_rst_l = 0;
      m_act = 0; m_idx = 0; m_done = 0;
      repeat (2) @(posedge clk_2);
      #1 int_rst_l = 1;
   endtask

   // Run en until done; en is random while the model index is in [lo,hi]
   task automatic run_to_done(input int lo, input int hi, input string name,
                              output int ens, output int lasts);
      bit e, got;
      ens = 0; lasts = 0; got = 0;
      for (int i = 0; i < 5000 && !got; i++) begin
         e = (m_idx >= lo && m_idx <= hi) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (e) ens++;
         cycle(0, e, name);
         if (last) lasts++;
         if (done) got = 1;
      end
      n_chk++;
      if (got) n_pass++;
      else $display("FAIL %s_timeout: got no done want done", name);
   endtask

   task automatic steps(input int n, input string name);
      for (int i = 0; i < n; i++) cycle(0, 1, name);
   endtask

   typedef struct {
      bit         s;
      bit         e;
      logic [14:0] exp;  // {addr, csp, cs0..3, last, busy, done}
   } vec_t;

   vec_t tbl[8];
   int ens, lasts;

   initial begin
      // Directed table from reset
      tbl[0] = '{0, 1, {7'd0, 5'b00000, 3'b000}};  // en ignored in IDLE
      tbl[1] = '{1, 0, {7'd0, 5'b10000, 3'b010}};  // start -> P0
      tbl[2] = '{0, 1, {7'd1, 5'b10000, 3'b010}};
      tbl[3] = '{0, 0, {7'd1, 5'b10000, 3'b010}};  // hold
      tbl[4] = '{0, 1, {7'd2, 5'b10000, 3'b010}};
      tbl[5] = '{1, 1, {7'd0, 5'b10000, 3'b010}};  // start beats en
      tbl[6] = '{0, 1, {7'd1, 5'b10000, 3'b010}};
      tbl[7] = '{0, 1, {7'd2, 5'b10000, 3'b010}};

      #1;
      chk("reset_state", outs(), 15'd0);
      do_reset();
      chk("reset_release", outs(), 15'd0);

      foreach (tbl[i]) begin
         cycle(tbl[i].s, tbl[i].e, "table_model");
         chk($sformatf("table_%0d", i), outs(), tbl[i].exp);
      end

      // 1: asynchronous reset mid-cycle, no clock edge in between
      #2 int_rst_l = 0;
      #1 chk("async_reset", outs(), 15'd0);
      do_reset();

      // 2: full uninterrupted run
      cycle(1, 0, "full_start");
      run_to_done(-1, -1, "full", ens, lasts);
      chk("full_en_count", 15'(ens), 15'(TOTAL));
      chk("full_last_count", 15'(lasts), 15'd1);
      cycle(0, 0, "full_done_drop");
      chk("done_one_cycle", {14'd0, done}, 15'd0);

      // 3: P -> S0 boundary
      cycle(1, 0, "bnd_start");
      steps(8, "bnd_p");
      chk("bnd_p8", outs(), {7'd8, 5'b10000, 3'b010});
      cycle(0, 1, "bnd_step");
      chk("bnd_s0_0", outs(), {7'd0, 5'b01000, 3'b010});

      // 4: random stalls across S1
      cycle(1, 0, "stall_start");
      run_to_done(9 + 128, 9 + 255, "stall", ens, lasts);
      chk("stall_en_count", 15'(ens), 15'(TOTAL));

      // 5: restart from S2 addr 40, no done
      cycle(1, 0, "rst2_start");
      steps(9 + 256 + 40, "rst2_walk");
      chk("s2_a40", outs(), {7'd40, 5'b00010, 3'b010});
      cycle(1, 0, "restart");
      chk("restart_p0", outs(), {7'd0, 5'b10000, 3'b010});

      // start on the final step wins, no done
      steps(TOTAL - 1, "final_walk");
      chk("at_last", outs(), {7'd127, 5'b00001, 3'b110});
      cycle(1, 1, "final_start");
      chk("final_start_p0", outs(), {7'd0, 5'b10000, 3'b010});

      // 6: reset mid S1, then a clean sequence with gaps
      steps(9 + 128 + 20, "s1_walk");
      @(negedge clk_2);
      int_rst_l = 0;
      #1 chk("reset_mid_s1", outs(), 15'd0);
      do_reset();
      cycle(1, 0, "post_rst_start");
      run_to_done(0, TOTAL - 1, "post_rst", ens, lasts);
      chk("post_rst_en_count", 15'(ens), 15'(TOTAL));

      // Random start/en mix
      for (int i = 0; i < 4000; i++)
         cycle(($urandom_range(0, 599) == 0), 1'($urandom_range(0, 3) != 0), "random");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
